// File: rtl/fifo_arbiter.sv
// Round-robin arbiter that drains several FWFT input FIFOs into one output FIFO in bounded bursts.
// Optional macro FIFO_ARBITER_PORT_ID_EN adds the w_port source-index output.
module fifo_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned WIDTH_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [WIDTH-1:0]         r_empty,
    output logic [WIDTH-1:0]         r_req,
    input  logic [WIDTH*DATA_W-1:0]  r_data,
    input  logic                     w_full,
    output logic                     w_req,
    output logic [DATA_W-1:0]        w_data
`ifdef FIFO_ARBITER_PORT_ID_EN
    ,
    output logic [WIDTH_W-1:0]       w_port
`endif
);

    localparam int unsigned DBL_W = 2 * WIDTH;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t               r_state;
    logic [WIDTH_W-1:0]   r_ptr;
    logic [WIDTH_W-1:0]   r_g;
    logic [7:0]           r_cnt;

    logic [DBL_W-1:0]     w_dbl;
    logic [WIDTH-1:0]     w_rot;
    logic                 w_any;
    logic [WIDTH_W-1:0]   w_sel;
    logic                 w_gempty;
    logic [DATA_W-1:0]    w_head;
    logic                 w_rd;
    logic [WIDTH_W-1:0]   w_gnext;
    logic                 w_last;

    // Rotate the non-empty mask so bit 0 is the port at ptr; the lowest set bit wins.
    assign w_dbl = {~r_empty, ~r_empty};
    assign w_rot = WIDTH'(w_dbl >> r_ptr);

    always_comb begin
        int unsigned sum;
        w_any = 1'b0;
        w_sel = '0;
        sum   = 0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (!w_any && w_rot[k]) begin
                w_any = 1'b1;
                sum   = 32'(r_ptr) + k;
                if (sum >= WIDTH) sum = sum - WIDTH;
                w_sel = WIDTH_W'(sum);
            end
        end
    end

    // Granted port's empty flag and head word.
    always_comb begin
        w_gempty = 1'b1;
        w_head   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (WIDTH_W'(i) == r_g) begin
                w_gempty = r_empty[i];
                w_head   = r_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_rd    = nrst & (r_state == ST_GRANT) & ~w_gempty & ~w_full;
    assign w_gnext = (r_g == WIDTH_W'(WIDTH - 1)) ? '0 : r_g + WIDTH_W'(1);
    assign w_last  = (r_cnt == 8'(BURST_LEN - 1));

    always_comb begin
        r_req = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (WIDTH_W'(i) == r_g) r_req[i] = w_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_g     <= '0;
            r_cnt   <= '0;
            w_req   <= 1'b0;
            w_data  <= '0;
`ifdef FIFO_ARBITER_PORT_ID_EN
            w_port  <= '0;
`endif
        end else begin
            w_req <= w_rd;
            if (w_rd) begin
                w_data <= w_head;
`ifdef FIFO_ARBITER_PORT_ID_EN
                w_port <= r_g;
`endif
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_sel;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_rd) r_cnt <= r_cnt + 8'd1;
                    // Drained port or exhausted burst both hand the turn to the next port.
                    if (w_gempty || (w_rd && w_last)) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_gnext;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Scoreboard bench for fifo_arbiter: queue-modelled FWFT input FIFOs feed the DUT, a negedge monitor checks writes.
module tb_fifo_arbiter;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned WIDTH_W   = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BURST_LEN = 4;

    logic                    clk = 1'b0;
    logic                    nrst;
    logic [WIDTH-1:0]        r_empty;
    logic [WIDTH-1:0]        r_req;
    logic [WIDTH*DATA_W-1:0] r_data;
    logic                    w_full;
    logic                    w_req;
    logic [DATA_W-1:0]       w_data;
`ifdef FIFO_ARBITER_PORT_ID_EN
    logic [WIDTH_W-1:0]      w_port;
`endif

    fifo_arbiter #(
        .WIDTH    (WIDTH),
        .WIDTH_W  (WIDTH_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .r_empty(r_empty),
        .r_req  (r_req),
        .r_data (r_data),
        .w_full (w_full),
        .w_req  (w_req),
        .w_data (w_data)
`ifdef FIFO_ARBITER_PORT_ID_EN
        ,
        .w_port (w_port)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DATA_W-1:0]  fq [WIDTH][$];
    logic [DATA_W-1:0]  exp_data[$];
    logic [WIDTH_W-1:0] exp_port[$];
    int                 wcyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int test, input int port, input int idx);
        return {4'(test), 4'(port), 24'(idx)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FWFT input FIFO model: pop on r_req, present the new head after the edge.
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (r_req[i]) begin
                check("read_nonempty", 64'(fq[i].size() > 0), 64'd1);
                if (fq[i].size() > 0) void'(fq[i].pop_front());
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            r_empty[i] <= (fq[i].size() == 0);
            r_data[i*DATA_W +: DATA_W] <= (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    end

    // Monitor: one-hot read strobes and in-order write checking.
    always @(negedge clk) begin
        check("r_req_onehot", 64'($onehot0(r_req)), 64'd1);
        if (w_req === 1'b1) begin
            wcyc.push_back(cyc);
            if (exp_data.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", w_data, cyc);
            end else begin
                logic [DATA_W-1:0]  d;
                logic [WIDTH_W-1:0] p;
                d = exp_data.pop_front();
                p = exp_port.pop_front();
                check("w_data", 64'(w_data), 64'(d));
`ifdef FIFO_ARBITER_PORT_ID_EN
                check("w_port", 64'(w_port), 64'(p));
`endif
            end
        end
    end

    task automatic load(input int port, input int test, input int n, input int base);
        for (int i = 0; i < n; i++) fq[port].push_back(mk(test, port, base + i));
    endtask

    task automatic expect_w(input int port, input int test, input int idx);
        exp_data.push_back(mk(test, port, idx));
        exp_port.push_back(WIDTH_W'(port));
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (exp_data.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_data.size()), 64'd0);
        exp_data.delete();
        exp_port.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rreq(input string name, input int port);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_req[port] && n < 50);
        check(name, 64'(r_req[port]), 64'd1);
    endtask

    initial begin
        nrst   = 1'b0;
        w_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r_req", 64'(r_req), 64'd0);
        nrst = 1'b1;

        // Idle after reset with every input empty.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_r_req", 64'(r_req), 64'd0);
            check("idle_w_req", 64'(w_req), 64'd0);
            check("idle_w_data", 64'(w_data), 64'd0);
        end

        // All four ports loaded: 4-word bursts in round-robin order, one idle cycle between.
        wcyc.delete();
        for (int p = 0; p < 4; p++) load(p, 2, 8, 0);
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < 4; p++)
                for (int i = 0; i < 4; i++) expect_w(p, 2, b * 4 + i);
        wait_done("rr_drain", 200);
        check("rr_count", 64'(wcyc.size()), 64'd32);
        if (wcyc.size() == 32) begin
            check("rr_burst_span", 64'(wcyc[3] - wcyc[0]), 64'd3);
            check("rr_gap", 64'(wcyc[4] - wcyc[3]), 64'd2);
            check("rr_total_span", 64'(wcyc[31] - wcyc[0]), 64'd38);
        end

        // Only port 2 holds two words; leaves ptr at 3.
        load(2, 3, 2, 0);
        expect_w(2, 3, 0);
        expect_w(2, 3, 1);
        wait_done("p2_only", 50);

        // Ports 0 and 3 loaded: ptr=3 serves port 3 first, then wraps to port 0.
        load(0, 4, 1, 0);
        load(3, 4, 1, 0);
        expect_w(3, 4, 0);
        expect_w(0, 4, 0);
        wait_done("wrap", 50);

        // w_full stall mid-burst on port 1; the burst keeps its remaining count.
        wcyc.delete();
        load(1, 5, 6, 0);
        for (int i = 0; i < 6; i++) expect_w(1, 5, i);
        wait_rreq("stall_grant", 1);
        @(negedge clk);
        w_full = 1'b1;
        #1 check("stall_r_req0", 64'(r_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_r_req", 64'(r_req), 64'd0);
            check("stall_w_req", 64'(w_req), 64'd0);
        end
        w_full = 1'b0;
        wait_done("stall_drain", 50);
        check("stall_count", 64'(wcyc.size()), 64'd6);
        if (wcyc.size() == 6) begin
            check("stall_len", 64'(wcyc[1] - wcyc[0]), 64'd6);
            check("stall_resume", 64'(wcyc[3] - wcyc[1]), 64'd2);
            check("stall_burst_end", 64'(wcyc[4] - wcyc[3]), 64'd2);
        end

        // Reset mid-burst on port 2; port 1 loaded during reset wins next since ptr returns to 0.
        load(2, 6, 6, 0);
        expect_w(2, 6, 0);
        expect_w(1, 6, 100);
        for (int i = 1; i < 6; i++) expect_w(2, 6, i);
        wait_rreq("rst_grant", 2);
        @(negedge clk);
        nrst = 1'b0;
        load(1, 6, 1, 100);
        #1 check("rst_force_r_req", 64'(r_req), 64'd0);
        @(negedge clk);
        check("rst_w_req", 64'(w_req), 64'd0);
        check("rst_w_data", 64'(w_data), 64'd0);
        nrst = 1'b1;
        wait_done("rst_drain", 100);
        for (int i = 0; i < WIDTH; i++) check("fifo_left", 64'(fq[i].size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
